trail_painter: RTL and testbench

// - Upstream writer for the frame buffer scanned by the display compositor. Once per frame tick it paints each bike's head

---
 rtl/tron_pkg.sv | 49 ++++
 rtl/fb_clear_sweep.sv | 31 +++
 rtl/trail_painter.sv | 207 ++++++++++++++++++++
 tb/tb_trail_painter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared constants and helpers for the trail painter: screen geometry,
// colour indices, frame-buffer addressing and the painter state encoding.
package tron_pkg;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int FB_WORDS     = DEF_SCREEN_W * DEF_SCREEN_H / 2;

    // Colour indices as they appear in a frame-buffer nibble
    localparam logic [3:0] COLOR_BG   = 4'h0;
    localparam logic [3:0] COLOR_GRID = 4'h8;
    localparam logic [3:0] COLOR_RED  = 4'h5;
    localparam logic [3:0] COLOR_BLUE = 4'h3;

    // Previous-position value that can never match a real head position
    localparam logic [9:0] POS_INVALID = 10'h3FF;

    // Painter FSM states
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LATCH  = 4'd1;
    localparam logic [3:0] ST_R_RD   = 4'd2;
    localparam logic [3:0] ST_R_WAIT = 4'd3;
    localparam logic [3:0] ST_R_WR   = 4'd4;
    localparam logic [3:0] ST_B_RD   = 4'd5;
    localparam logic [3:0] ST_B_WAIT = 4'd6;
    localparam logic [3:0] ST_B_WR   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;
    localparam logic [3:0] ST_SWEEP  = 4'd9;

    // Word address of a pixel: two pixels share one 16-bit word
    function automatic logic [18:0] fb_addr(input logic [9:0] x, input logic [9:0] y,
                                            input int width);
        int a;
        a = int'(x[9:1]) + int'(y) * (width / 2);
        return a[18:0];
    endfunction

    // True when the pixel lies on the visible screen
    function automatic logic in_bounds(input logic [9:0] x, input logic [9:0] y,
                                       input int width, input int height);
        return (int'(x) < width) && (int'(y) < height);
    endfunction

    // A nibble counts as free space if it is background or grid
    function automatic logic is_empty(input logic [3:0] nib);
        return (nib == COLOR_BG) || (nib == COLOR_GRID);
    endfunction

endpackage

// File: rtl/fb_clear_sweep.sv
// Frame-buffer clear sweep: after reset, walks every word address once,
// one write of zero per clock, while enabled by the painter FSM.
module fb_clear_sweep
    import tron_pkg::*;
#(
    parameter int WORDS = FB_WORDS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        enable,
    output logic        sweep_we,
    output logic [18:0] sweep_addr,
    output logic        sweep_last
);

    logic [18:0] count;

    // Word counter, restarts from zero on every reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (enable) begin
            count <= sweep_last ? '0 : count + 19'd1;
        end
    end

    assign sweep_we   = enable;
    assign sweep_addr = count;
    assign sweep_last = (count == 19'(WORDS - 1));

endmodule

// File: rtl/trail_painter.sv
// Trail painter: on every frame tick paints the red and blue bike heads into
// the 2-pixel/word frame buffer with a read-modify-write and raises sticky
// crash flags when a head lands on an occupied pixel or leaves the screen.
// Optional build macro FB_CLEAR_EN adds a zero-fill sweep after reset.
module trail_painter
    import tron_pkg::*;
#(
    parameter int         SCREEN_W  = DEF_SCREEN_W,
    parameter int         SCREEN_H  = DEF_SCREEN_H,
    parameter logic [3:0] RED_COLOR = COLOR_RED,
    parameter logic [3:0] BLU_COLOR = COLOR_BLUE
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  red_X,
    input  logic [9:0]  red_Y,
    input  logic [9:0]  blue_X,
    input  logic [9:0]  blue_Y,
    input  logic        clear_crash,
    output logic [18:0] rd_address,
    input  logic [15:0] rd_data,
    output logic [18:0] write_address,
    output logic [15:0] Data_In,
    output logic        WE,
    output logic        red_crash,
    output logic        blue_crash,
    output logic        busy,
    output logic        done
);

`ifdef FB_CLEAR_EN
    localparam logic [3:0] ST_AFTER_RESET = ST_SWEEP;
`else
    localparam logic [3:0] ST_AFTER_RESET = ST_IDLE;
`endif

    logic [3:0]  state;
    logic        frame_q;
    logic        tick;
    logic [9:0]  lat_rx, lat_ry, lat_bx, lat_by;
    logic [9:0]  prev_rx, prev_ry, prev_bx, prev_by;
    logic [3:0]  rd_lo, rd_hi;
    logic        blue_phase;
    logic [9:0]  cur_x, cur_y, cur_px, cur_py;
    logic [3:0]  cur_color, cur_nib;
    logic        cur_in, cur_moved, cur_hit, same_px;
    logic [18:0] cur_addr;
    logic [15:0] merged;
    logic        paint_we;
    logic        red_set, blue_set;
    logic        sweep_we, sweep_last;
    logic [18:0] sweep_addr;
    logic        unused_rd_bits;

    assign unused_rd_bits = ^{rd_data[15:12], rd_data[7:4]};

    // Frame tick is the rising edge of frame_clk as seen on Clk
    always_ff @(posedge Clk) begin
        frame_q <= frame_clk;
    end

    assign tick = frame_clk & ~frame_q;

    // Painter sequencer: one Clk per state, ticks only accepted in IDLE
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_AFTER_RESET;
        end else begin
            case (state)
                ST_IDLE:   if (tick) state <= ST_LATCH;
                ST_LATCH:  state <= ST_R_RD;
                ST_R_RD:   state <= ST_R_WAIT;
                ST_R_WAIT: state <= ST_R_WR;
                ST_R_WR:   state <= ST_B_RD;
                ST_B_RD:   state <= ST_B_WAIT;
                ST_B_WAIT: state <= ST_B_WR;
                ST_B_WR:   state <= ST_DONE;
                ST_DONE:   state <= ST_IDLE;
                ST_SWEEP:  if (sweep_last) state <= ST_DONE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Position capture, read-data capture and previous-position history
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            lat_rx  <= '0;
            lat_ry  <= '0;
            lat_bx  <= '0;
            lat_by  <= '0;
            prev_rx <= POS_INVALID;
            prev_ry <= POS_INVALID;
            prev_bx <= POS_INVALID;
            prev_by <= POS_INVALID;
            rd_lo   <= '0;
            rd_hi   <= '0;
        end else begin
            if (state == ST_LATCH) begin
                lat_rx <= red_X;
                lat_ry <= red_Y;
                lat_bx <= blue_X;
                lat_by <= blue_Y;
            end
            if (state == ST_R_WAIT || state == ST_B_WAIT) begin
                rd_lo <= rd_data[3:0];
                rd_hi <= rd_data[11:8];
            end
            if (state == ST_B_WR) begin
                prev_rx <= lat_rx;
                prev_ry <= lat_ry;
                prev_bx <= lat_bx;
                prev_by <= lat_by;
            end
        end
    end

    // Select the bike being worked on and build its collision test and merged word
    always_comb begin
        blue_phase = (state == ST_B_RD) || (state == ST_B_WAIT) || (state == ST_B_WR);
        cur_x      = blue_phase ? lat_bx : lat_rx;
        cur_y      = blue_phase ? lat_by : lat_ry;
        cur_px     = blue_phase ? prev_bx : prev_rx;
        cur_py     = blue_phase ? prev_by : prev_ry;
        cur_color  = blue_phase ? BLU_COLOR : RED_COLOR;
        cur_in     = in_bounds(cur_x, cur_y, SCREEN_W, SCREEN_H);
        cur_addr   = fb_addr(cur_x, cur_y, SCREEN_W);
        cur_nib    = cur_x[0] ? rd_hi : rd_lo;
        cur_moved  = (cur_x != cur_px) || (cur_y != cur_py);
        cur_hit    = !cur_in || (cur_moved && !is_empty(cur_nib));
        same_px    = (lat_rx == lat_bx) && (lat_ry == lat_by) &&
                     in_bounds(lat_rx, lat_ry, SCREEN_W, SCREEN_H);
        merged     = '0;
        if (cur_x[0]) begin
            merged[11:8] = cur_color;
            merged[3:0]  = rd_lo;
        end else begin
            merged[3:0]  = cur_color;
            merged[11:8] = rd_hi;
        end
    end

    // Frame-buffer port drive; reset kills the write enable without waiting a clock
    always_comb begin
        paint_we      = ((state == ST_R_WR) || (state == ST_B_WR)) && cur_in;
        rd_address    = '0;
        if ((state == ST_R_RD || state == ST_R_WAIT || state == ST_B_RD ||
             state == ST_B_WAIT) && cur_in) begin
            rd_address = cur_addr;
        end
        WE            = Reset && (paint_we || sweep_we);
        write_address = '0;
        Data_In       = '0;
        if (sweep_we) begin
            write_address = sweep_addr;
        end else if (paint_we) begin
            write_address = cur_addr;
            Data_In       = merged;
        end
        busy          = (state != ST_IDLE);
    end

    // Crash set conditions; a shared head pixel marks both bikes
    always_comb begin
        red_set  = ((state == ST_R_WR) && cur_hit) || ((state == ST_B_WR) && same_px);
        blue_set = (state == ST_B_WR) && (cur_hit || same_px);
    end

    // Sticky crash flags: clear_crash clears, a simultaneous set still wins
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            red_crash  <= 1'b0;
            blue_crash <= 1'b0;
        end else begin
            red_crash  <= (red_crash  & ~clear_crash) | red_set;
            blue_crash <= (blue_crash & ~clear_crash) | blue_set;
        end
    end

    // One-cycle done pulse following the DONE state
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
        end
    end

`ifdef FB_CLEAR_EN
    fb_clear_sweep #(
        .WORDS (SCREEN_W * SCREEN_H / 2)
    ) u_sweep (
        .Clk        (Clk),
        .Reset      (Reset),
        .enable     (state == ST_SWEEP),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .sweep_last (sweep_last)
    );
`else
    assign sweep_we   = 1'b0;
    assign sweep_addr = '0;
    assign sweep_last = 1'b0;
`endif

endmodule

// File: tb/tb_trail_painter.sv
// Self-checking bench for trail_painter: a behavioural frame-buffer RAM,
// directed cases for the documented corner behaviours, then randomized frames
// compared against a pixel-level reference model.
module tb_trail_painter;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int WORDS = W * H / 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  red_X, red_Y, blue_X, blue_Y;
    logic        clear_crash;
    logic [18:0] rd_address;
    logic [15:0] rd_data;
    logic [18:0] write_address;
    logic [15:0] Data_In;
    logic        WE;
    logic        red_crash, blue_crash;
    logic        busy, done;

    int vectors     = 0;
    int miscompares = 0;

    // Frame-buffer contents as seen by the DUT, and as predicted by the model
    logic [15:0] mem     [0:WORDS-1];
    logic [15:0] ref_mem [0:WORDS-1];

    // Model state
    bit          m_rc, m_bc;
    logic [9:0]  m_prx, m_pry, m_pbx, m_pby;
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          got_addr[$];
    logic [15:0] got_data[$];

    trail_painter dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .red_X         (red_X),
        .red_Y         (red_Y),
        .blue_X        (blue_X),
        .blue_Y        (blue_Y),
        .clear_crash   (clear_crash),
        .rd_address    (rd_address),
        .rd_data       (rd_data),
        .write_address (write_address),
        .Data_In       (Data_In),
        .WE            (WE),
        .red_crash     (red_crash),
        .blue_crash    (blue_crash),
        .busy          (busy),
        .done          (done)
    );

    // 100 MHz system clock
    always #5 Clk = ~Clk;

    // Synchronous RAM: registered read port, write port owned by the DUT
    always @(posedge Clk) begin
        rd_data <= mem[rd_address];
        if (WE) mem[write_address] <= Data_In;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for one bike: bounds, collision test and nibble merge at pixel level
    task automatic model_bike(input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] px, input logic [9:0] py,
                              input logic [3:0] col, output bit hit);
        int          addr;
        logic [15:0] w, nw;
        logic [3:0]  nib;
        if (x >= W || y >= H) begin
            hit = 1'b1;
            return;
        end
        addr = x / 2 + y * (W / 2);
        w    = ref_mem[addr];
        nib  = x[0] ? w[11:8] : w[3:0];
        hit  = !(x == px && y == py) && !(nib == 4'h0 || nib == 4'h8);
        nw   = 16'h0000;
        if (x[0]) begin
            nw[11:8] = col;
            nw[3:0]  = w[3:0];
        end else begin
            nw[3:0]  = col;
            nw[11:8] = w[11:8];
        end
        ref_mem[addr] = nw;
        exp_addr.push_back(addr);
        exp_data.push_back(nw);
    endtask

    // Reference for a whole frame; a clear inside the frame lands no later than red's set
    task automatic model_frame(input logic [9:0] rx, input logic [9:0] ry,
                               input logic [9:0] bx, input logic [9:0] by, input bit clr);
        bit rh, bh, same;
        exp_addr.delete();
        exp_data.delete();
        model_bike(rx, ry, m_prx, m_pry, 4'h5, rh);
        model_bike(bx, by, m_pbx, m_pby, 4'h3, bh);
        same = (rx == bx) && (ry == by) && (rx < W) && (ry < H);
        if (clr) begin
            m_rc = 1'b0;
            m_bc = 1'b0;
        end
        m_rc  = m_rc | rh | same;
        m_bc  = m_bc | bh | same;
        m_prx = rx;
        m_pry = ry;
        m_pbx = bx;
        m_pby = by;
    endtask

    // Drive one frame tick, watch the DUT for 14 clocks and check the outcome
    task automatic applyStimulus(input logic [9:0] rx, input logic [9:0] ry,
                                 input logic [9:0] bx, input logic [9:0] by,
                                 input int clr_k, input bit retick, input string tag);
        int done_k = 0;
        int done_cnt = 0;
        model_frame(rx, ry, bx, by, clr_k != 0);
        got_addr.delete();
        got_data.delete();
        red_X     = rx;
        red_Y     = ry;
        blue_X    = bx;
        blue_Y    = by;
        frame_clk = 1'b1;
        for (int p = 1; p <= 14; p++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (p == 1) checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
            if (WE) begin
                got_addr.push_back(int'(write_address));
                got_data.push_back(Data_In);
            end
            if (done) begin
                done_cnt++;
                if (done_k == 0) done_k = p;
            end
            if (p == 2) frame_clk = 1'b0;
            if (retick && p == 3) frame_clk = 1'b1;
            if (retick && p == 5) frame_clk = 1'b0;
            clear_crash = (p == clr_k);
        end
        clear_crash = 1'b0;
        checkOutput({tag, "_done_lat"}, 64'(done_k - 1), 64'd8);
        checkOutput({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checkOutput({tag, "_waddr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            checkOutput({tag, "_wdata"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
        checkOutput({tag, "_red_crash"}, 64'(red_crash), 64'(m_rc));
        checkOutput({tag, "_blue_crash"}, 64'(blue_crash), 64'(m_bc));
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // One-cycle clear_crash pulse while the painter is idle
    task automatic clear_pulse();
        clear_crash = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        clear_crash = 1'b0;
        m_rc = 1'b0;
        m_bc = 1'b0;
        checkOutput("clear_red", 64'(red_crash), 64'd0);
        checkOutput("clear_blue", 64'(blue_crash), 64'd0);
    endtask

    // Preload a word in both the RAM and the model
    task automatic preset_word(input int addr, input logic [15:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    // Reset during red's write state: WE must drop at once and nothing is written
    task automatic reset_midframe();
        int addr;
        addr      = 30 / 2 + 30 * (W / 2);
        red_X     = 10'd30;
        red_Y     = 10'd30;
        blue_X    = 10'd31;
        blue_Y    = 10'd30;
        frame_clk = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (p == 2) frame_clk = 1'b0;
        end
        checkOutput("midrst_we_before", 64'(WE), 64'd1);
        Reset = 1'b0;
        #1;
        checkOutput("midrst_we_now", 64'(WE), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_red", 64'(red_crash), 64'd0);
        checkOutput("midrst_word", 64'(mem[addr]), 64'(ref_mem[addr]));
        Reset = 1'b1;
        @(negedge Clk);
        m_rc  = 1'b0;
        m_bc  = 1'b0;
        m_prx = 10'h3FF;
        m_pry = 10'h3FF;
        m_pbx = 10'h3FF;
        m_pby = 10'h3FF;
    endtask

    // Random head position: mostly a small crowded patch, some off-screen or stationary
    task automatic pick_pos(input logic [9:0] px, input logic [9:0] py,
                            output logic [9:0] x, output logic [9:0] y);
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
            x = 10'(W + int'($urandom_range(0, 7)));
            y = 10'($urandom_range(0, 3));
        end else if (r == 1) begin
            x = 10'($urandom_range(0, 7));
            y = 10'(H + int'($urandom_range(0, 3)));
        end else if (r <= 3) begin
            x = px;
            y = py;
        end else begin
            x = 10'($urandom_range(0, 7));
            y = 10'($urandom_range(0, 3));
        end
    endtask

    // Directed corner cases followed by randomized frames
    initial begin
        logic [3:0]  nibs [0:7];
        logic [9:0]  rx, ry, bx, by;
        nibs = '{4'h0, 4'h8, 4'h3, 4'h5, 4'h0, 4'h0, 4'h8, 4'h1};
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        Reset       = 1'b0;
        frame_clk   = 1'b0;
        clear_crash = 1'b0;
        red_X       = '0;
        red_Y       = '0;
        blue_X      = '0;
        blue_Y      = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);

        checkOutput("rst_we", 64'(WE), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_red", 64'(red_crash), 64'd0);
        checkOutput("rst_blue", 64'(blue_crash), 64'd0);
        checkOutput("rst_rdaddr", 64'(rd_address), 64'd0);
        checkOutput("rst_waddr", 64'(write_address), 64'd0);
        checkOutput("rst_data", 64'(Data_In), 64'd0);

        Reset = 1'b1;
        @(negedge Clk);
        m_rc  = 1'b0;
        m_bc  = 1'b0;
        m_prx = 10'h3FF;
        m_pry = 10'h3FF;
        m_pbx = 10'h3FF;
        m_pby = 10'h3FF;

        applyStimulus(10'd10, 10'd20, 10'd11, 10'd20, 0, 1'b0, "share_word");
        preset_word(100, 16'h0003);
        applyStimulus(10'd200, 10'd0, 10'd300, 10'd300, 0, 1'b0, "red_hits_blue");
        clear_pulse();
        applyStimulus(10'd50, 10'd50, 10'd50, 10'd50, 0, 1'b0, "same_head");
        clear_pulse();
        applyStimulus(10'd640, 10'd5, 10'd12, 10'd20, 0, 1'b0, "red_oob");
        clear_pulse();
        applyStimulus(10'd100, 10'd100, 10'd101, 10'd100, 0, 1'b0, "stat_first");
        applyStimulus(10'd100, 10'd100, 10'd102, 10'd100, 0, 1'b1, "stat_retick");
        applyStimulus(10'd640, 10'd0, 10'd101, 10'd100, 0, 1'b0, "both_set");
        applyStimulus(10'd101, 10'd100, 10'd110, 10'd100, 4, 1'b0, "clr_vs_set");
        reset_midframe();

        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                logic [3:0] lo, hi;
                lo = nibs[$urandom_range(0, 7)];
                hi = nibs[$urandom_range(0, 7)];
                preset_word(yy * (W / 2) + xx, {4'h0, hi, 4'h0, lo});
            end
        end
        for (int f = 0; f < 40; f++) begin
            pick_pos(m_prx, m_pry, rx, ry);
            pick_pos(m_pbx, m_pby, bx, by);
            if ($urandom_range(0, 7) == 0) begin
                bx = rx;
                by = ry;
            end
            if ($urandom_range(0, 3) == 0) clear_pulse();
            applyStimulus(rx, ry, bx, by, ($urandom_range(0, 4) == 0) ? 4 : 0,
                          1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
